// File: rtl/riscv_boot_ctrl.sv
// Boot sequencer for the single-cycle RISC-V core: streams an image into
// instruction memory under core reset, runs it, and halts on breakpoint or cycle budget.
module riscv_boot_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   ld_count,
  input  logic              abort,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  input  logic [31:0]       cpu_pc,
  input  logic              halt_en,
  input  logic [31:0]       halt_addr,
  output logic              running,
  output logic              done,
  output logic [1:0]        halt_reason,
  output logic [31:0]       run_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam bit              BUDGET_ON = (MAX_CYCLES != 0);
  localparam logic [31:0]     LAST_CYC  = 32'(MAX_CYCLES - 1);

  localparam logic [1:0] HR_NONE   = 2'b00;
  localparam logic [1:0] HR_BREAK  = 2'b01;
  localparam logic [1:0] HR_BUDGET = 2'b10;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      reason_q;
  logic [1:0]      reason_d;
  logic            cpu_reset_q;
  logic [ADDR_W:0] idx_q;
  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] cnt_in;
  logic [31:0]     run_q;

  logic start_ok;
  logic xfer;
  logic last_word;
  logic bp_hit;
  logic bud_hit;
  logic run_entry;
  logic run_sat;

  // Handshake qualifiers and halt conditions.
  always_comb begin
    start_ok  = load_start & ~abort &
                ((state_q == S_IDLE) | (state_q == S_DONE));
    xfer      = (state_q == S_LOAD) & ld_valid & ~abort;
    last_word = (idx_q == (cnt_q - ONE_C));
    bp_hit    = halt_en & (cpu_pc == halt_addr);
    bud_hit   = BUDGET_ON & (run_q == LAST_CYC);
    cnt_in    = (ld_count > DEPTH_C) ? DEPTH_C : ld_count;
    run_sat   = (run_q == '1);
  end

  // Next-state and halt-reason selection; abort overrides everything.
  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          reason_d = HR_NONE;
          if (ld_count == '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (xfer && last_word) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bp_hit) begin
          state_d  = S_DONE;
          reason_d = HR_BREAK;
        end else if (bud_hit) begin
          state_d  = S_DONE;
          reason_d = HR_BUDGET;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      reason_d = HR_NONE;
    end
  end

  assign run_entry = (state_d == S_RUN) & (state_q != S_RUN);

  // State, core reset and halt reason registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cpu_reset_q <= 1'b1;
      reason_q    <= HR_NONE;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= (state_d != S_RUN);
      reason_q    <= reason_d;
    end
  end

  // Load word index and latched, clamped word count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else if (start_ok) begin
      idx_q <= '0;
      cnt_q <= cnt_in;
    end else if (xfer) begin
      idx_q <= idx_q + ONE_C;
    end
  end

  // Run-cycle counter: cleared on RUN entry, saturating, held on abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= '0;
    end else if (abort) begin
      run_q <= run_q;
    end else if (run_entry) begin
      run_q <= '0;
    end else if ((state_q == S_RUN) && !run_sat) begin
      run_q <= run_q + 32'd1;
    end
  end

  // Output decode.
  always_comb begin
    ld_ready    = (state_q == S_LOAD);
    imem_we     = xfer & ld_ready;
    imem_addr   = idx_q[ADDR_W-1:0];
    imem_wdata  = ld_data;
    cpu_reset   = cpu_reset_q;
    running     = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    halt_reason = reason_q;
    run_cycles  = run_q;
  end

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Directed and randomized bench for riscv_boot_ctrl with a
// behavioural core PC model and arithmetic halt prediction.
module tb_riscv_boot_ctrl;

  localparam int AW    = 4;
  localparam int MC    = 10;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_start = 1'b0;
  logic [AW:0]   ld_count = '0;
  logic          abort = 1'b0;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_data = '0;
  logic          ld_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic [31:0]   cpu_pc;
  logic          halt_en = 1'b0;
  logic [31:0]   halt_addr = '0;
  logic          running;
  logic          done;
  logic [1:0]    halt_reason;
  logic [31:0]   run_cycles;

  int checks = 0;
  int errors = 0;

  logic        pc_loop = 1'b0;
  logic [31:0] core_pc = '0;
  logic [31:0] prog [4] = '{32'h00500093, 32'h00100113,
                            32'h002081B3, 32'h0000006F};

  riscv_boot_ctrl #(
    .ADDR_W(AW),
    .MAX_CYCLES(MC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_start(load_start),
    .ld_count(ld_count),
    .abort(abort),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_ready(ld_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset),
    .cpu_pc(cpu_pc),
    .halt_en(halt_en),
    .halt_addr(halt_addr),
    .running(running),
    .done(done),
    .halt_reason(halt_reason),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  assign cpu_pc = core_pc;

  // Abstract core: PC pinned at 0 in reset, else sequential or self-loop.
  always @(posedge clk) begin
    if (cpu_reset) core_pc <= '0;
    else if (!pc_loop) core_pc <= core_pc + 32'd4;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cpu_rst"}, cpu_reset, 1);
    chk({tag, "_ld_rdy"}, ld_ready, 0);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_run"}, running, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_hr"}, halt_reason, 0);
    chk({tag, "_rc"}, run_cycles, 0);
  endtask

  task automatic load_prog(input int n_req, input bit gaps);
    int n;
    int idx;
    int gap_run;
    logic [31:0] w;
    n = (n_req > DEPTH) ? DEPTH : n_req;
    ld_count = (AW+1)'(n_req);
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    chk("start_hr", halt_reason, 0);
    if (n == 0) begin
      chk("direct_run", running, 1);
      chk("direct_rst", cpu_reset, 0);
      chk("direct_we", imem_we, 0);
    end else begin
      chk("ld_ready", ld_ready, 1);
      idx = 0;
      gap_run = 0;
      for (int c = 0; c < 300 && idx < n; c++) begin
        if (gaps && gap_run < 3) ld_valid = 1'($urandom_range(0, 1));
        else ld_valid = 1'b1;
        if (ld_valid) gap_run = 0;
        else gap_run++;
        w = (idx < 4) ? prog[idx] : $urandom;
        ld_data = w;
        #1;
        chk("we", imem_we, ld_valid);
        if (ld_valid) begin
          chk("addr", imem_addr, idx);
          chk("wdata", imem_wdata, w);
        end
        @(posedge clk);
        #1;
        if (ld_valid) idx++;
        if (idx < n) chk("hold_rst", cpu_reset, 1);
      end
      ld_valid = 1'b0;
      chk("load_cnt", idx, n);
      chk("run_entry", running, 1);
      chk("rst_fall", cpu_reset, 0);
    end
  endtask

  task automatic run_expect(input int k, input logic [1:0] why);
    int c;
    c = 0;
    while (!done && c < 60) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("halt_cycles", c, k);
    chk("done", done, 1);
    chk("reason", halt_reason, why);
    chk("run_cycles", run_cycles, k);
    chk("done_rst", cpu_reset, 1);
    chk("done_run", running, 0);
    tick;
    tick;
    chk("hold_rc", run_cycles, k);
    chk("hold_hr", halt_reason, why);
  endtask

  initial begin
    int n_req;
    int k;
    int exp_k;
    logic [1:0] exp_r;

    #12;
    chk_reset_vals("por");
    #6;
    reset = 1'b1;
    tick;
    chk("idle_rst", cpu_reset, 1);
    chk("idle_rdy", ld_ready, 0);

    // Breakpoint at 0x0C after a gapped 4-word load.
    halt_en = 1'b1;
    halt_addr = 32'h0000000C;
    load_prog(4, 1'b1);
    run_expect(4, 2'b01);

    // Cycle budget with a self-looping core.
    halt_en = 1'b0;
    pc_loop = 1'b1;
    load_prog(4, 1'b0);
    run_expect(MC, 2'b10);
    pc_loop = 1'b0;

    // Breakpoint on the final budget cycle wins.
    halt_en = 1'b1;
    halt_addr = 32'(4 * (MC - 1));
    load_prog(2, 1'b1);
    run_expect(MC, 2'b01);

    // Oversized count clamps to memory depth.
    halt_en = 1'b0;
    load_prog(20, 1'b1);
    run_expect(MC, 2'b10);

    // Abort during LOAD together with a valid word.
    ld_count = 5'd5;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    ld_valid = 1'b1;
    ld_data = 32'hDEADBEEF;
    tick;
    abort = 1'b1;
    #1;
    chk("abort_we", imem_we, 0);
    tick;
    abort = 1'b0;
    ld_valid = 1'b0;
    chk("abort_run", running, 0);
    chk("abort_done", done, 0);
    chk("abort_rdy", ld_ready, 0);
    chk("abort_rst", cpu_reset, 1);
    chk("abort_hr", halt_reason, 0);

    // Zero-length load runs directly; abort in RUN holds run_cycles.
    load_prog(0, 1'b0);
    tick;
    chk("run_no_we", imem_we, 0);
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_rc", run_cycles, 2);
    chk("abort2_rst", cpu_reset, 1);
    chk("abort2_run", running, 0);

    // Asynchronous reset in the middle of a run.
    load_prog(3, 1'b0);
    tick;
    tick;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge clk);
    reset = 1'b1;
    tick;
    halt_en = 1'b1;
    halt_addr = 32'h0000000C;
    load_prog(4, 1'b1);
    run_expect(4, 2'b01);

    // Randomized restarts from DONE against the halt rules.
    for (int it = 0; it < 8; it++) begin
      n_req = $urandom_range(0, 20);
      halt_en = 1'($urandom_range(0, 1));
      k = $urandom_range(1, 14);
      halt_addr = 32'(4 * (k - 1));
      if (halt_en && k <= MC) begin
        exp_k = k;
        exp_r = 2'b01;
      end else begin
        exp_k = MC;
        exp_r = 2'b10;
      end
      load_prog(n_req, 1'($urandom_range(0, 1)));
      run_expect(exp_k, exp_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_boot_ctrl.md
Name: riscv_boot_ctrl

Overview:
- Sequences the single-cycle RISC-V core.
- Holds the core in reset while a program image is streamed word-by-word into instruction memory, then releases the core.
- Monitors PC for a breakpoint and enforces a run-cycle budget.
- On either halt event, re-asserts core reset and reports why it stopped. Sits between the host/loader stream, the instruction memory write port, and the core's reset input.

Parameters:
- ADDR_W, 8: instruction-memory word-address width (depth 2**ADDR_W words).
- MAX_CYCLES, 1000000: run-cycle budget per run; 0 = unlimited.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- load_start  input  1  single-cycle pulse: begin load (IDLE/DONE only)
- ld_count  input  ADDR_W+1  words to load, sampled on accepted load_start; 0 = run without loading
- abort  input  1  return to IDLE from any state
- ld_valid  input  1  loader word valid
- ld_data  input  32  loader word
- ld_ready  output  1  controller accepts a word this cycle
- imem_we  output  1  instruction-memory write enable
- imem_addr  output  ADDR_W  instruction-memory word address
- imem_wdata  output  32  instruction-memory write data
- cpu_reset  output  1  active-high reset to the core
- cpu_pc  input  32  core PC (byte address)
- halt_en  input  1  breakpoint enable
- halt_addr  input  32  breakpoint PC
- running  output  1  state == RUN
- done  output  1  state == DONE
- halt_reason  output  2  00 none, 01 breakpoint, 10 cycle budget, 11 reserved
- run_cycles  output  32  cycles executed in the current/last run

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cpu_reset=1, ld_ready=0, imem_we=0, imem_addr=0, running=0, done=0, halt_reason=00, run_cycles=0.
- States: IDLE, LOAD, RUN, DONE. State and cpu_reset are registered.
- IDLE: cpu_reset=1.
  - load_start with ld_count>0 -> LOAD; word index=0; count latched.
  - load_start with ld_count==0 -> RUN.
  - load_start has no effect in LOAD/RUN.
- LOAD:
  - ld_ready=1.
  - Transfer occurs when ld_valid & ld_ready (both sampled at the rising edge).
  - imem_we = ld_valid & ld_ready & ~abort, combinational.
  - imem_addr = word index register; imem_wdata = ld_data.
  - Index increments after each transfer.
  - After the transfer of word ld_count-1 -> RUN next cycle.
  - ld_valid low simply stalls; there is no timeout.
  - ld_count > 2**ADDR_W is clamped to 2**ADDR_W.
- RUN:
  - cpu_reset=0 from the first RUN cycle.
  - run_cycles clears on RUN entry, then increments every RUN cycle (saturates at 2**32-1).
  - Breakpoint: halt_en & (cpu_pc==halt_addr) in a RUN cycle -> DONE next edge, halt_reason=01. The instruction at halt_addr completes (its writeback commits at that same edge).
  - Budget: MAX_CYCLES!=0 and run_cycles reaches MAX_CYCLES-1 -> DONE, halt_reason=10. Exactly MAX_CYCLES core cycles execute.
  - Breakpoint and budget in the same cycle: breakpoint wins (01).
- DONE:
  - cpu_reset=1, done=1; run_cycles and halt_reason hold.
  - load_start restarts as from IDLE; halt_reason clears to 00 on leaving DONE.
- abort (any state, priority over all other transitions): next state IDLE, cpu_reset=1, run_cycles held, halt_reason=00; no imem write in the abort cycle.
- Asynchronous reset mid-LOAD or mid-RUN: immediate return to reset values. Partially loaded memory contents are not cleared.
- halt_addr and halt_en are sampled every RUN cycle and may change while running.

Test Plan:
- Reset, then load_start with ld_count=4; stream 0x00500093, 0x00100113, 0x002081B3, 0x0000006F with ld_valid gaps -> exactly four imem_we pulses at addr 0..3 with matching data; cpu_reset falls the cycle after the 4th transfer; running=1.
- Run with halt_en=1, halt_addr=0x0000000C -> done=1 and halt_reason=01 one edge after cpu_pc==0x0C; cpu_reset=1; run_cycles=4.
- MAX_CYCLES=10, halt_en=0, self-loop program -> DONE after exactly 10 RUN cycles, halt_reason=10, run_cycles=10.
- Breakpoint PC coincides with the final budget cycle -> halt_reason=01.
- abort asserted together with a valid transfer in LOAD -> no imem_we that cycle; state IDLE; cpu_reset=1. A later load_start with ld_count=0 -> RUN directly, no writes.
- reset driven low mid-RUN (not clock-aligned) -> cpu_reset=1 and running=0 immediately; all outputs at reset values; load_start after release proceeds normally.
